// File: rtl/dcsk_rx.sv
// DCSK receiver: per bit, SF reference chips then SF data chips; majority of chip matches decides the bit.
// Latency 2*SF*MSG_W+1 cycles from start to o_valid; no backpressure, one frame at a time, starts ignored while busy.
module dcsk_rx #(
    parameter int MSG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_rx,
    input  logic             i_start,
    input  logic [1:0]       i_sf,
    output logic [MSG_W-1:0] o_msg,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_tie
);

    localparam int BW = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    typedef enum logic [1:0] {IDLE, REF, DATA, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       sf_id;
    logic [5:0]       chip_cnt;
    logic [6:0]       match_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [63:0]      ref_buf;
    logic [MSG_W-1:0] shreg;

    logic [5:0]       chip_last;
    logic [6:0]       half;
    logic [6:0]       match_tot;
    logic             chip_end;
    logic             last_bit;
    logic             bit_dec;
    logic             bit_tie;
    logic [MSG_W-1:0] shift_nxt;

    always_comb begin
        chip_last = 6'd7;
        half      = 7'd4;
        case (sf_id)
            2'd0: begin chip_last = 6'd7;  half = 7'd4;  end
            2'd1: begin chip_last = 6'd15; half = 7'd8;  end
            2'd2: begin chip_last = 6'd31; half = 7'd16; end
            2'd3: begin chip_last = 6'd63; half = 7'd32; end
            default: ;
        endcase
    end

    // Count including the chip arriving this cycle, so the decision is ready on the last data chip.
    assign match_tot = match_cnt + {6'd0, (i_rx == ref_buf[chip_cnt])};
    assign chip_end  = (chip_cnt == chip_last);
    assign last_bit  = (bit_cnt == BW'(MSG_W - 1));
    assign bit_dec   = (match_tot >= half);
    assign bit_tie   = (match_tot == half);
    assign shift_nxt = MSG_W'({shreg, bit_dec});
    assign o_busy    = (state == REF) || (state == DATA);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = REF;
            REF:  if (chip_end) state_nxt = DATA;
            DATA: if (chip_end) state_nxt = last_bit ? DONE : REF;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= IDLE;
            sf_id     <= 2'd0;
            chip_cnt  <= 6'd0;
            match_cnt <= 7'd0;
            bit_cnt   <= '0;
            shreg     <= '0;
            o_msg     <= '0;
            o_valid   <= 1'b0;
            o_tie     <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sf_id     <= i_sf;
                        o_tie     <= 1'b0;
                        bit_cnt   <= '0;
                        chip_cnt  <= 6'd0;
                        match_cnt <= 7'd0;
                    end
                end
                REF: begin
                    chip_cnt <= chip_end ? 6'd0 : chip_cnt + 6'd1;
                end
                DATA: begin
                    chip_cnt  <= chip_end ? 6'd0 : chip_cnt + 6'd1;
                    match_cnt <= chip_end ? 7'd0 : match_tot;
                    if (chip_end) begin
                        shreg <= shift_nxt;
                        if (bit_tie) o_tie <= 1'b1;
                        if (last_bit) begin
                            // o_msg and o_valid both become visible in the DONE cycle.
                            o_msg   <= shift_nxt;
                            o_valid <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reference chips are always rewritten before use, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (state == REF) ref_buf[chip_cnt] <= i_rx;
    end

endmodule

// File: tb/tb_dcsk_rx.sv
// Directed bench for dcsk_rx: scoreboard of expected frames checked when o_valid fires.
module tb_dcsk_rx;

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_rx = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_sf = 2'd0;
    logic [31:0] o_msg;
    logic        o_valid;
    logic        o_busy;
    logic        o_tie;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] msg;
        logic        tie;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prev_msg = 32'd0;

    dcsk_rx #(.MSG_W(32)) dut (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_rx     (i_rx),
        .i_start  (i_start),
        .i_sf     (i_sf),
        .o_msg    (o_msg),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_tie    (o_tie)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Output monitor: every o_valid pops one expected frame; o_msg must hold otherwise.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_arst_n) begin
            if (o_valid) begin
                chk("valid_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("msg", 64'(o_msg), 64'(e.msg));
                    chk("tie", 64'(o_tie), 64'(e.tie));
                    chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
                end
            end else begin
                chk("msg_hold", 64'(o_msg), 64'(prev_msg));
            end
        end
        prev_msg = o_msg;
    end

    // Drives start then all chips; returns in the DONE cycle. glitch_bit >= 0 pulses a
    // start with a different SF during that bit's reference segment.
    task automatic drive_frame(input logic [31:0] msg, input logic [1:0] sf, input int flips,
                               input int glitch_bit, input logic [31:0] exp_msg, input logic exp_tie);
        int          n;
        logic [63:0] refs[32];
        logic [63:0] dats[32];
        n = 8 << sf;
        for (int b = 0; b < 32; b++) begin
            refs[b] = {$urandom, $urandom};
            dats[b] = msg[31 - b] ? refs[b] : ~refs[b];
            for (int i = 0; i < flips; i++) dats[b][i] = ~dats[b][i];
        end
        sb.push_back('{msg: exp_msg, tie: exp_tie, cyc: cyc, lat: 2 * n * 32 + 1});
        i_start = 1'b1;
        i_sf    = sf;
        step();
        i_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            for (int i = 0; i < n; i++) begin
                i_rx = refs[b][i];
                if (b == glitch_bit && i == 3) begin
                    i_start = 1'b1;
                    i_sf    = ~sf;
                end
                step();
                i_start = 1'b0;
            end
            for (int i = 0; i < n; i++) begin
                i_rx = dats[b][i];
                step();
            end
        end
        i_rx = 1'b0;
    endtask

    initial begin
        logic [31:0] m1;
        logic [31:0] m2;

        step();
        step();
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_msg", 64'(o_msg), 64'd0);
        chk("rst_tie", 64'(o_tie), 64'd0);
        i_arst_n = 1'b1;

        // Clean SF=8 frame, started on the first edge after reset release.
        drive_frame(32'hA5A5A5A5, 2'd0, 0, -1, 32'hA5A5A5A5, 1'b0);
        step();
        step();

        // Abort in the middle of a DATA segment.
        i_start = 1'b1;
        i_sf    = 2'd0;
        step();
        i_start = 1'b0;
        repeat (12) begin
            i_rx = $urandom_range(0, 1);
            step();
        end
        chk("busy_before_abort", 64'(o_busy), 64'd1);
        i_arst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_valid", 64'(o_valid), 64'd0);
        chk("abort_msg", 64'(o_msg), 64'd0);
        step();
        i_arst_n = 1'b1;
        step();
        chk("post_abort_msg", 64'(o_msg), 64'd0);

        // SF=64 with 31 of 64 chips corrupted per bit.
        drive_frame(32'h0F0F1234, 2'd3, 31, -1, 32'h0F0F1234, 1'b0);
        step();
        step();

        // SF=16, every bit an exact 8/16 tie.
        drive_frame(32'h12345678, 2'd1, 8, -1, 32'hFFFFFFFF, 1'b1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("done_start_lost", 64'(o_busy), 64'd0);
        chk("tie_sticky", 64'(o_tie), 64'd1);
        step();
        chk("still_idle", 64'(o_busy), 64'd0);
        chk("tie_sticky2", 64'(o_tie), 64'd1);

        // Start pulse with a new SF mid-frame must not restart or retime.
        drive_frame(32'h3C5AF00F, 2'd0, 0, 5, 32'h3C5AF00F, 1'b0);
        step();

        // Back-to-back frames: second start one cycle after DONE.
        m1 = $urandom;
        m2 = $urandom;
        drive_frame(m1, 2'd2, 3, -1, m1, 1'b0);
        step();
        drive_frame(m2, 2'd0, 1, -1, m2, 1'b0);
        step();
        step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: observed no completion expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dcsk_rx.md
DCSK_RX -- requirements
Module: dcsk_rx

Interface
REQ-001 SHALL have parameter MSG_W, default 32, giving the message width in bits.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-003 SHALL have port i_arst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_rx, input, 1 bit: received chip stream, one chip per clock.
REQ-005 SHALL have port i_start, input, 1 bit: frame start strobe; first reference chip arrives on the next cycle.
REQ-006 SHALL have port i_sf, input, 2 bits: spreading-factor ID (0->8, 1->16, 2->32, 3->64 chips per segment).
REQ-007 SHALL have port o_msg, output, MSG_W bits: last decoded message.
REQ-008 SHALL have port o_valid, output, 1 bit: one-cycle pulse when o_msg updates.
REQ-009 SHALL have port o_busy, output, 1 bit: high while a frame is being received.
REQ-010 SHALL have port o_tie, output, 1 bit: sticky per-frame flag; set if any bit decision was an exact tie.

Function
REQ-011 SHALL implement an FSM with states IDLE, REF, DATA and DONE.
REQ-012 In IDLE, i_start=1 SHALL latch i_sf into an internal SF register, clear o_tie, bit counter and chip counter, and move to REF next cycle.
REQ-013 i_sf changes after latching SHALL have no effect until the next frame.
REQ-014 In REF, each cycle SHALL store i_rx into a reference buffer at index chip_cnt (0..SF-1); after SF chips, SHALL move to DATA with chip_cnt reset to 0.
REQ-015 In DATA, each cycle SHALL compare i_rx with ref[chip_cnt] and increment a 7-bit match counter on equality.
REQ-016 After SF data chips, the decided bit SHALL be 1 if match_cnt >= SF/2, else 0.
REQ-017 An exact tie (match_cnt == SF/2) SHALL decide 1 and set o_tie.
REQ-018 Decided bits SHALL be shifted MSB-first into a MSG_W-bit shift register; match_cnt SHALL clear per bit.
REQ-019 After a bit that is not the last, the FSM SHALL return to REF for the next bit; the reference buffer SHALL be overwritten for every bit.
REQ-020 After bit MSG_W-1, the FSM SHALL enter DONE for exactly one cycle.
REQ-021 In DONE, o_msg SHALL load the shift register and o_valid SHALL be 1; the FSM SHALL then return to IDLE.
REQ-022 o_valid SHALL be high exactly one cycle per frame, 2*SF*MSG_W+1 cycles after the i_start cycle.
REQ-023 o_msg SHALL hold its value until the next DONE; it SHALL NOT change during a frame.
REQ-024 o_busy SHALL be 1 in REF and DATA and 0 in IDLE and DONE.
REQ-025 i_start SHALL be ignored in REF, DATA and DONE; a start presented in the DONE cycle SHALL be lost.
REQ-026 o_tie SHALL hold from its setting until the next accepted i_start.
REQ-027 Counters SHALL never wrap within a frame: chip_cnt max 63, match_cnt max 64, bit counter max MSG_W-1.

Reset
REQ-028 While i_arst_n=0, the FSM SHALL be IDLE and o_msg, o_valid, o_busy, o_tie, all counters, and the shift register SHALL be 0; the reference buffer need not reset.
REQ-029 Reset asserted mid-frame SHALL abort immediately with no o_valid, leaving o_msg=0.
REQ-030 After release, the block SHALL accept i_start from the first rising edge.

Verification
REQ-031 Reset: assert i_arst_n=0 mid-DATA -> o_busy=0, o_valid=0, o_msg=0x00000000 in the same cycle.
REQ-032 sf=0, clean DCSK chips (data segment = ref for 1, ~ref for 0) of 0xA5A5A5A5 -> o_valid at cycle 513 after start, o_msg=0xA5A5A5A5, o_tie=0.
REQ-033 sf=3, 0x0F0F1234, 31 of 64 data chips flipped per bit -> o_msg=0x0F0F1234 at cycle 4097.
REQ-034 sf=1, every bit with exactly 8/16 matches -> o_msg=0xFFFFFFFF, o_tie=1.
REQ-035 i_start pulsed mid-frame with i_sf changed -> no restart; original SF timing holds; one o_valid.
REQ-036 Back-to-back: i_start one cycle after the DONE cycle -> second frame decodes correctly; o_msg changes only at the second o_valid.
